// File: rtl/lvda_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lvda_addr_pkg
// Purpose  : Shared types and helpers for the PIO address decode.
//            - pio_state_t : PIO command state encoding.
//            - c_PH_*      : bit positions of the phase strobes in the
//                            phase vector.
//            - parity_error: odd-parity check over address plus parity bit.
// Revision : 1.0  initial release
// ============================================================================
package lvda_addr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } pio_state_t;

    // Phase strobe positions within the packed phase vector
    localparam int c_PH_V1  = 0;
    localparam int c_PH_V4  = 1;
    localparam int c_PH_W7  = 2;
    localparam int c_PH_X3  = 3;
    localparam int c_PH_Y3  = 4;
    localparam int c_PH_Z7  = 5;
    localparam int c_NUM_PH = 6;

    // Address and parity bit together must carry an odd number of ones.
    // The address is zero-extended to 64 bits; the extra zeros do not
    // change the reduction.
    function automatic logic parity_error(input logic [63:0] addr,
                                          input logic        par);
        return ~(^{addr, par});
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_bit_cell.sv
`default_nettype none
// ============================================================================
// Module   : address_bit_cell
// Purpose  : One latched PIO address bit.
//            Priority: load > set > clear > hold.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            i_load,i_d  - load strobe and data
//            i_set       - force bit to 1
//            i_clear     - force bit to 0
//            o_q         - registered bit
//            o_next      - value the bit takes at the next edge
// Revision : 1.0  initial release
// ============================================================================
module address_bit_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_d,
    input  logic i_set,
    input  logic i_clear,
    output logic o_q,
    output logic o_next
);

    logic w_next;

    always_comb begin
        w_next = o_q;
        if (i_load) begin
            w_next = i_d;
        end else if (i_set) begin
            w_next = 1'b1;
        end else if (i_clear) begin
            w_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= 1'b0;
        end else begin
            o_q <= w_next;
        end
    end

    // Exposed so the channel decode can be registered from the post-load value
    assign o_next = w_next;

endmodule
`default_nettype wire

// File: rtl/pio_address_decode.sv
`default_nettype none
// ============================================================================
// Module   : pio_address_decode
// Purpose  : Latches the PIO address from phase-timed address lines, runs
//            the PIO command FSM (PIOD), generates PARS/DINF/DARO strobes,
//            decodes the address into a one-hot channel select and checks
//            address parity.
// Ports    : SIM_CLK, SIM_RST        - clock, async active-low reset
//            V1,V4,W7,X3,Y3,Z7       - phase strobes
//            ADDR_IN, PAR_IN         - address lines and odd-parity bit
//            PIOV..TRSV              - qualifier lines
//            ADDR_Q                  - latched address
//            PIOD, PARS, DINF, DARO  - control outputs
//            DSEL                    - one-hot channel select
//            PERR                    - sticky parity error
// Revision : 1.0  initial release
// ============================================================================
module pio_address_decode #(
    parameter int ADDR_W    = 9,
    parameter int CH_W      = 4,
    parameter int DIR_BIT   = 7,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   V1,
    input  logic                   V4,
    input  logic                   W7,
    input  logic                   X3,
    input  logic                   Y3,
    input  logic                   Z7,
    input  logic [ADDR_W-1:0]      ADDR_IN,
    input  logic                   PAR_IN,
    input  logic                   PIOV,
    input  logic                   PIODV,
    input  logic                   PAAV,
    input  logic                   ADV,
    input  logic                   G1DV,
    input  logic                   G3DV,
    input  logic                   G6DV,
    input  logic                   PARSV,
    input  logic                   AI3V,
    input  logic                   TRSV,
    output logic [ADDR_W-1:0]      ADDR_Q,
    output logic                   PIOD,
    output logic                   PARS,
    output logic                   DINF,
    output logic                   DARO,
    output logic [(2**CH_W)-1:0]   DSEL,
    output logic                   PERR
);

    import lvda_addr_pkg::*;

    localparam int c_NUM_CH = 2**CH_W;

    logic [c_NUM_PH-1:0] w_phase;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_load;
    logic                w_clr_cmd;
    logic                w_set_cmd;
    logic                w_start;
    logic                w_dainf_set;
    logic                w_daro_set;
    logic                w_unused;
    logic                r_dainf;
    pio_state_t          r_state;
    pio_state_t          w_state_next;
    logic [c_NUM_CH-1:0] w_dsel_next;

    assign w_phase[c_PH_V1] = V1;
    assign w_phase[c_PH_V4] = V4;
    assign w_phase[c_PH_W7] = W7;
    assign w_phase[c_PH_X3] = X3;
    assign w_phase[c_PH_Y3] = Y3;
    assign w_phase[c_PH_Z7] = Z7;

    // V1 has no function in this block; kept for pin compatibility with LVDA.
    // PAR_IN is unused when parity checking is compiled out.
    assign w_unused = ^{w_phase[c_PH_V1], PAR_IN};

    // ------------------------------------------------------------------
    // Address register
    // ------------------------------------------------------------------
    assign w_load    = w_phase[c_PH_Y3] & PIODV;
    assign w_clr_cmd = w_phase[c_PH_V4] & PARSV;
    assign w_set_cmd = w_phase[c_PH_X3] & PAAV & ADV & ~G6DV & ~G1DV;

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_bit
            // Bits 0-1 are only ever set; upper bits are only ever cleared
            address_bit_cell u_cell (
                .clk     (SIM_CLK),
                .rst_n   (SIM_RST),
                .i_load  (w_load),
                .i_d     (ADDR_IN[gi]),
                .i_set   ((gi < 2) ? w_set_cmd : 1'b0),
                .i_clear ((gi >= 2) ? w_clr_cmd : 1'b0),
                .o_q     (ADDR_Q[gi]),
                .o_next  (w_addr_next[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // PIO command FSM
    // ------------------------------------------------------------------
    assign w_start = w_phase[c_PH_W7] & PIOV & PAAV & ADV & ~G6DV & ~G1DV;

    always_comb begin
        w_state_next = r_state;
        w_dsel_next  = '0;
        case (r_state)
            IDLE:    if (w_start)                  w_state_next = ARMED;
            ARMED:   if (w_phase[c_PH_V4])         w_state_next = ACTIVE;
            ACTIVE:  if (w_phase[c_PH_X3] & ~ADV)  w_state_next = IDLE;
            default:                               w_state_next = IDLE;
        endcase
        // Decode from the next address so a load during ACTIVE is seen at once
        if (w_state_next == ACTIVE) begin
            w_dsel_next[w_addr_next[CH_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_state <= IDLE;
            PIOD    <= 1'b0;
            DSEL    <= '0;
        end else begin
            r_state <= w_state_next;
            PIOD    <= (w_state_next == ACTIVE);
            DSEL    <= w_dsel_next;
        end
    end

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    assign w_dainf_set = w_phase[c_PH_W7] &
                         ((AI3V & ~ADDR_Q[DIR_BIT]) | (TRSV & ADDR_Q[DIR_BIT]));
    assign w_daro_set  = w_phase[c_PH_W7] & PIODV & ~ADV & ~ADDR_Q[DIR_BIT] &
                         (ADDR_Q[1:0] == 2'b11);

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            PARS    <= 1'b0;
            r_dainf <= 1'b0;
            DINF    <= 1'b0;
            DARO    <= 1'b0;
        end else begin
            PARS <= w_phase[c_PH_V4] & PAAV & G6DV & ~G3DV;

            // Set takes precedence over a coincident Z7 clear
            if (w_dainf_set) begin
                r_dainf <= 1'b1;
            end else if (w_phase[c_PH_Z7]) begin
                r_dainf <= 1'b0;
            end

            if (w_phase[c_PH_Y3]) begin
                DINF <= r_dainf;
            end

            if (w_daro_set) begin
                DARO <= 1'b1;
            end else if (w_phase[c_PH_Z7]) begin
                DARO <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address parity
    // ------------------------------------------------------------------
    generate
        if (PARITY_EN) begin : g_parity
            logic w_par_err;
            assign w_par_err = parity_error({{(64-ADDR_W){1'b0}}, ADDR_IN}, PAR_IN);

            // A load coinciding with PARS restarts the flag from that load
            always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
                if (!SIM_RST) begin
                    PERR <= 1'b0;
                end else if (PARS) begin
                    PERR <= w_load & w_par_err;
                end else if (w_load) begin
                    PERR <= PERR | w_par_err;
                end
            end
        end else begin : g_no_parity
            assign PERR = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pio_address_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_address_decode
// Purpose  : Directed self-checking bench for pio_address_decode.
// Revision : 1.0  initial release
// ============================================================================
module tb_pio_address_decode;

    logic        SIM_CLK;
    logic        SIM_RST;
    logic        V1, V4, W7, X3, Y3, Z7;
    logic [8:0]  ADDR_IN;
    logic        PAR_IN;
    logic        PIOV, PIODV, PAAV, ADV, G1DV, G3DV, G6DV, PARSV, AI3V, TRSV;
    logic [8:0]  ADDR_Q;
    logic        PIOD, PARS, DINF, DARO, PERR;
    logic [15:0] DSEL;

    int checks = 0;
    int errors = 0;

    pio_address_decode #(
        .ADDR_W    (9),
        .CH_W      (4),
        .DIR_BIT   (7),
        .PARITY_EN (1'b1)
    ) dut (
        .SIM_CLK (SIM_CLK), .SIM_RST (SIM_RST),
        .V1 (V1), .V4 (V4), .W7 (W7), .X3 (X3), .Y3 (Y3), .Z7 (Z7),
        .ADDR_IN (ADDR_IN), .PAR_IN (PAR_IN),
        .PIOV (PIOV), .PIODV (PIODV), .PAAV (PAAV), .ADV (ADV),
        .G1DV (G1DV), .G3DV (G3DV), .G6DV (G6DV), .PARSV (PARSV),
        .AI3V (AI3V), .TRSV (TRSV),
        .ADDR_Q (ADDR_Q), .PIOD (PIOD), .PARS (PARS), .DINF (DINF),
        .DARO (DARO), .DSEL (DSEL), .PERR (PERR)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic clr_in();
        {V1, V4, W7, X3, Y3, Z7} = '0;
        {PIOV, PIODV, PAAV, ADV, G1DV, G3DV, G6DV, PARSV, AI3V, TRSV} = '0;
        ADDR_IN = '0;
        PAR_IN  = 1'b0;
    endtask

    // Inputs are applied after a falling edge; this advances past the next
    // rising edge to the following falling edge, then clears all inputs.
    task automatic step();
        @(negedge SIM_CLK);
        clr_in();
    endtask

    task automatic load(input logic [8:0] a, input logic p);
        Y3 = 1'b1; PIODV = 1'b1; ADDR_IN = a; PAR_IN = p;
        step();
    endtask

    task automatic test_reset();
        clr_in();
        SIM_RST = 1'b0;
        #1;
        checks++;
        if ({ADDR_Q, PIOD, PARS, DINF, DARO, DSEL, PERR} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h piod=%b pars=%b dinf=%b daro=%b dsel=%h perr=%b want all 0",
                     ADDR_Q, PIOD, PARS, DINF, DARO, DSEL, PERR);
        end
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        step();
    endtask

    task automatic test_load_clear();
        load(9'h1A5, 1'b0);  // five ones -> odd with parity 0
        checks++;
        if (ADDR_Q !== 9'h1A5) begin errors++; $display("FAIL load_addr: got %h want %h", ADDR_Q, 9'h1A5); end
        checks++;
        if (PERR !== 1'b0) begin errors++; $display("FAIL load_good_parity: got %b want 0", PERR); end

        V4 = 1'b1; PARSV = 1'b1;
        step();
        checks++;
        if (ADDR_Q !== 9'h001) begin errors++; $display("FAIL clear_upper: got %h want %h", ADDR_Q, 9'h001); end

        X3 = 1'b1; PAAV = 1'b1; ADV = 1'b1;
        step();
        checks++;
        if (ADDR_Q !== 9'h003) begin errors++; $display("FAIL set_low: got %h want %h", ADDR_Q, 9'h003); end

        // Load and set together: load wins
        Y3 = 1'b1; PIODV = 1'b1; ADDR_IN = 9'h104; PAR_IN = 1'b1;
        X3 = 1'b1; PAAV = 1'b1; ADV = 1'b1;
        step();
        checks++;
        if (ADDR_Q !== 9'h104) begin errors++; $display("FAIL load_over_set: got %h want %h", ADDR_Q, 9'h104); end
    endtask

    task automatic test_pio();
        load(9'h005, 1'b1);
        V4 = 1'b1;  // V4 in IDLE must not start a command
        step();
        checks++;
        if (PIOD !== 1'b0) begin errors++; $display("FAIL pio_idle_v4: got %b want 0", PIOD); end

        W7 = 1'b1; PIOV = 1'b1; PAAV = 1'b1; ADV = 1'b1;
        step();
        checks++;
        if (PIOD !== 1'b0) begin errors++; $display("FAIL pio_armed: got %b want 0", PIOD); end

        V4 = 1'b1;
        step();
        checks++;
        if (PIOD !== 1'b1) begin errors++; $display("FAIL pio_active: got %b want 1", PIOD); end
        checks++;
        if (DSEL !== 16'h0020) begin errors++; $display("FAIL pio_dsel: got %h want %h", DSEL, 16'h0020); end

        X3 = 1'b1; ADV = 1'b1;  // ADV high keeps the command going
        step();
        checks++;
        if (PIOD !== 1'b1) begin errors++; $display("FAIL pio_hold_adv: got %b want 1", PIOD); end

        X3 = 1'b1;
        step();
        checks++;
        if (PIOD !== 1'b0) begin errors++; $display("FAIL pio_end: got %b want 0", PIOD); end
        checks++;
        if (DSEL !== 16'h0000) begin errors++; $display("FAIL pio_end_dsel: got %h want 0000", DSEL); end
    endtask

    task automatic test_parity();
        load(9'h1A5, 1'b1);  // five ones + 1 -> even -> error
        checks++;
        if (PERR !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b want 1", PERR); end

        load(9'h005, 1'b1);  // good load must not clear the sticky flag
        checks++;
        if (PERR !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b want 1", PERR); end

        V4 = 1'b1; PAAV = 1'b1; G6DV = 1'b1;
        step();
        checks++;
        if (PARS !== 1'b1) begin errors++; $display("FAIL pars_pulse: got %b want 1", PARS); end
        step();
        checks++;
        if (PARS !== 1'b0) begin errors++; $display("FAIL pars_one_cycle: got %b want 0", PARS); end
        checks++;
        if (PERR !== 1'b0) begin errors++; $display("FAIL parity_cleared: got %b want 0", PERR); end
    endtask

    task automatic test_dinf();
        W7 = 1'b1; AI3V = 1'b1;  // address 005, DIR bit 0
        step();
        Y3 = 1'b1;
        step();
        checks++;
        if (DINF !== 1'b1) begin errors++; $display("FAIL dinf_ai3v: got %b want 1", DINF); end

        Z7 = 1'b1; step();
        Y3 = 1'b1; step();
        checks++;
        if (DINF !== 1'b0) begin errors++; $display("FAIL dinf_clear: got %b want 0", DINF); end

        load(9'h080, 1'b0);  // DIR bit 1
        W7 = 1'b1; TRSV = 1'b1; step();
        Y3 = 1'b1; step();
        checks++;
        if (DINF !== 1'b1) begin errors++; $display("FAIL dinf_trsv: got %b want 1", DINF); end

        Z7 = 1'b1; step();
        W7 = 1'b1; AI3V = 1'b1; step();  // AI3V ignored on telemetry path
        Y3 = 1'b1; step();
        checks++;
        if (DINF !== 1'b0) begin errors++; $display("FAIL dinf_wrong_path: got %b want 0", DINF); end
    endtask

    task automatic test_daro();
        load(9'h003, 1'b1);
        W7 = 1'b1; PIODV = 1'b1;
        step();
        checks++;
        if (DARO !== 1'b1) begin errors++; $display("FAIL daro_set: got %b want 1", DARO); end

        Z7 = 1'b1; step();
        checks++;
        if (DARO !== 1'b0) begin errors++; $display("FAIL daro_clear: got %b want 0", DARO); end

        W7 = 1'b1; PIODV = 1'b1; Z7 = 1'b1;
        step();
        checks++;
        if (DARO !== 1'b1) begin errors++; $display("FAIL daro_set_wins: got %b want 1", DARO); end

        Z7 = 1'b1; step();
        W7 = 1'b1; PIODV = 1'b1; ADV = 1'b1;
        step();
        checks++;
        if (DARO !== 1'b0) begin errors++; $display("FAIL daro_adv_block: got %b want 0", DARO); end
    endtask

    task automatic test_reset_mid();
        W7 = 1'b1; PIOV = 1'b1; PAAV = 1'b1; ADV = 1'b1;
        step();
        W7 = 1'b1; PIODV = 1'b1; AI3V = 1'b1;  // ignored by FSM, sets DARO/DAINF
        step();
        Y3 = 1'b1; step();
        V4 = 1'b1; step();
        checks++;
        if ({PIOD, DSEL, DINF, DARO} !== {1'b1, 16'h0008, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_setup: got piod=%b dsel=%h dinf=%b daro=%b want 1 0008 1 1", PIOD, DSEL, DINF, DARO);
        end

        #2 SIM_RST = 1'b0;
        #1;
        checks++;
        if ({ADDR_Q, PIOD, DSEL, DINF, DARO, PARS, PERR} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got addr=%h piod=%b dsel=%h dinf=%b daro=%b want all 0",
                     ADDR_Q, PIOD, DSEL, DINF, DARO);
        end
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        step();
        V4 = 1'b1; step();  // only reaches ACTIVE if a stale ARMED survived
        checks++;
        if (PIOD !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got %b want 0", PIOD); end
    endtask

    initial begin
        test_reset();
        test_load_clear();
        test_pio();
        test_parity();
        test_dinf();
        test_daro();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_address_decode.md
# pio_address_decode

Parametrised successor to the LVDA fixed 9-bit address decode. It latches a PIO address of configurable width from the phase-timed address lines and runs an explicit PIO-command state machine that drives PIOD. It also generates the PARS, DAINF/DINF and DARO control strobes and decodes the latched address into a one-hot channel select, with optional odd-parity checking. It sits between the LVDA timing generator, which supplies the phase strobes, and the PIO channel logic.

## Interface
- ADDR_W, 9: latched address width (≥3).
- CH_W, 4: low address bits decoded into DSEL; NUM_CH = 2**CH_W.
- DIR_BIT, 7: address bit selecting input (0) vs telemetry (1) data path.
- PARITY_EN, 1: enables address parity check.
- SIM_CLK  in  1  system clock, all state on rising edge.
- SIM_RST  in  1  reset, asynchronous, active-low.
- V1, V4, W7, X3, Y3, Z7  in  1 each  one-cycle phase strobes from the timing generator.
- ADDR_IN  in  ADDR_W  address lines (A1V..AnV), bit 0 = A1.
- PAR_IN  in  1  odd-parity bit accompanying ADDR_IN.
- PIOV, PIODV, PAAV, ADV, G1DV, G3DV, G6DV, PARSV, AI3V, TRSV  in  1 each  qualifier lines.
- ADDR_Q  out  ADDR_W  latched address.
- PIOD  out  1  PIO command active.
- PARS  out  1  parity-reset pulse.
- DINF, DARO  out  1 each  data-in-flag and data-read-out strobes.
- DSEL  out  NUM_CH  one-hot channel select, all-zero unless PIOD.
- PERR  out  1  sticky address parity error.

## Operation
- All outputs reset to 0. FSM resets to IDLE. DAINF resets to 0.
- Address register, per bit:
  - Load ADDR_IN on Y3 & PIODV.
  - Else, on V4 & PARSV, clear bits 2..ADDR_W-1.
  - Else hold.
  - Bits 0–1 additionally set on X3 & PAAV & ADV & ~G6DV & ~G1DV.
  - Load has priority over clear and set.
- Parity: if PARITY_EN, on each load PERR <= PERR | ~(^{ADDR_IN,PAR_IN}). Cleared by PARS. If PARITY_EN=0, PERR is constant 0.
- PIO FSM (package enum):
  - IDLE → ARMED on W7 & PIOV & PAAV & ADV & ~G6DV & ~G1DV.
  - ARMED → ACTIVE on next V4; PIOD=1 in ACTIVE only.
  - ACTIVE → IDLE on X3 & ~ADV.
  - Any state → IDLE on reset. A W7 start seen while ARMED or ACTIVE is ignored.
- DSEL: while PIOD, DSEL[ADDR_Q[CH_W-1:0]] = 1; otherwise all zero. Registered together with the FSM state.
- PARS: one-cycle pulse in the cycle after V4 & PAAV & G6DV & ~G3DV.
- DAINF (internal):
  - Set on W7 & ((AI3V & ~ADDR_Q[DIR_BIT]) | (TRSV & ADDR_Q[DIR_BIT])).
  - Cleared on Z7. Set wins if both occur in the same cycle.
- DINF: sampled from DAINF on Y3, held otherwise.
- DARO:
  - Set on W7 & PIODV & ~ADV & ~ADDR_Q[DIR_BIT] & ADDR_Q[1:0]==2'b11.
  - Cleared on Z7. Set wins on a same-cycle conflict.

## Timing
- Every output is registered; one-cycle latency from the qualifying strobe edge.
- ADDR_Q reflects a Y3 load in the next cycle. DSEL uses the post-load value.
- PIOD rises one cycle after the V4 that follows an arming W7. It falls one cycle after the terminating X3.
- Phase strobes are mutually exclusive by contract. The priority rules above still hold if that contract is violated.
- Asserting reset mid-command drops PIOD, DSEL, DINF and DARO asynchronously. No stale state survives.

## Structure
- Package lvda_addr_pkg holds:
  - the FSM state enum (IDLE, ARMED, ACTIVE);
  - a phase-index constant set;
  - the parity function.
- Sub-module address_bit_cell: one latched address bit with load/clear/set inputs and load priority, instantiated ADDR_W times.
- The top level contains the FSM, DAINF/DINF/DARO/PARS, decode and parity logic.

## Test plan
- Reset: drive SIM_RST=0 mid-sequence → all outputs 0 immediately. After release, the FSM is IDLE.
- Load 9'h1A5 with correct parity on Y3&PIODV → ADDR_Q=1A5 and PERR=0. Then V4&PARSV → ADDR_Q=9'h001.
- Start PIO: W7 start → V4 → PIOD=1 and DSEL=16'h0020 (address 5). X3&~ADV → PIOD=0 and DSEL=0 on the next cycle.
- Bad parity on load → PERR=1 and stays 1 through further loads. A PARS pulse clears it.
- DIR_BIT=0, AI3V at W7 → DINF=1 at the following Y3. Z7 then Y3 → DINF=0. Repeat with TRSV and DIR_BIT=1.
- ADDR_Q[1:0]=3, PIODV, ~ADV at W7 → DARO=1. A simultaneous W7-set and Z7 keeps DARO=1.
